// File: rtl/ir_pkg.sv
// ---------------------------------------------------------------------------
// ir_pkg
//   Shared definitions for the NEC infrared transmitter and its receive-side
//   counterpart.
//   - Default segment lengths in 16 kHz ticks (one tick = 62.5 us). The
//     receiver's classification windows are built from the same values.
//   - ir_tx_state_t : transmit FSM state encoding. The repeat-code states
//     exist only when IR_TX_REPEAT_EN is defined.
//   - nec_encode()  : builds the 32-bit on-air word from a 16-bit key code.
//   - is_mark_state(): 1 for states that drive the LED on.
// ---------------------------------------------------------------------------
package ir_pkg;

  // Width of every tick counter. Every duration parameter must fit in it.
  localparam int unsigned IR_TIMER_W = 11;

  localparam int unsigned IR_LEAD_MARK    = 144;  // 9 ms
  localparam int unsigned IR_LEAD_SPACE   = 72;   // 4.5 ms
  localparam int unsigned IR_BIT_MARK     = 9;    // 562.5 us
  localparam int unsigned IR_ZERO_SPACE   = 9;    // logic 0 space
  localparam int unsigned IR_ONE_SPACE    = 27;   // logic 1 space
  localparam int unsigned IR_REP_SPACE    = 36;   // 2.25 ms repeat space
  localparam int unsigned IR_FRAME_PERIOD = 1728; // 108 ms leader-to-leader

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEAD_M,
    ST_LEAD_S,
    ST_BIT_M,
    ST_BIT_S,
    ST_STOP_M,
    ST_GAP
`ifdef IR_TX_REPEAT_EN
    ,
    ST_REP_M,
    ST_REP_S,
    ST_REP_STOP
`endif
  } ir_tx_state_t;

  // On-air word: each byte is preceded by its complement so the receiver can
  // validate it. Bit 31 goes out first.
  function automatic logic [31:0] nec_encode(input logic [15:0] data);
    return {~data[15:8], data[15:8], ~data[7:0], data[7:0]};
  endfunction

  function automatic logic is_mark_state(input ir_tx_state_t s);
    logic mark;
    mark = 1'b0;
    case (s)
      ST_LEAD_M, ST_BIT_M, ST_STOP_M: mark = 1'b1;
`ifdef IR_TX_REPEAT_EN
      ST_REP_M, ST_REP_STOP:          mark = 1'b1;
`endif
      default:                        mark = 1'b0;
    endcase
    return mark;
  endfunction

endpackage

// File: rtl/ir_nec_tx_if.sv
// ---------------------------------------------------------------------------
// ir_nec_tx_if
//   Request/status bundle between a key-scan client and the NEC transmitter.
//   - tx_data  [15:0] : key code, [15:8] high byte, [7:0] low byte
//   - tx_start        : transmit request, only looked at while idle
//   - tx_hold         : key still held (repeat request)
//   - tx_busy         : transmitter is occupied
//   - tx_done         : one-cycle pulse when the transmitter goes idle again
//   modport master : the client side
//   modport slave  : the transmitter side
// ---------------------------------------------------------------------------
interface ir_nec_tx_if;
  logic [15:0] tx_data;
  logic        tx_start;
  logic        tx_hold;
  logic        tx_busy;
  logic        tx_done;

  modport master (
    output tx_data,
    output tx_start,
    output tx_hold,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    input  tx_hold,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/ir_tick_timer.sv
// ---------------------------------------------------------------------------
// ir_tick_timer
//   Loadable down-counter that times one mark or space segment.
//   Ports:
//     slow_clk   : clock (16 kHz tick)
//     reset      : synchronous, active-high; clears the count
//     load       : load load_value on this edge (overrides counting)
//     load_value : segment length in ticks
//     value      : current count
//     expired    : count is 1, i.e. this is the last tick of the segment
//   After a load of N the count reads N, N-1, ..., 1 on N successive cycles,
//   so a segment loaded with N lasts exactly N cycles. The count rests at 0.
// ---------------------------------------------------------------------------
module ir_tick_timer #(
  parameter int unsigned WIDTH = 11
) (
  input  logic             slow_clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_value;
    end else if (value_q != '0) begin
      value_d = value_q - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge slow_clk) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value   = value_q;
  assign expired = (value_q == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/ir_nec_tx.sv
// ---------------------------------------------------------------------------
// ir_nec_tx
//   NEC infrared transmitter. Serialises a 16-bit key code as a 32-bit NEC
//   frame (leader, 32 pulse-distance bits MSB first, stop mark) on a baseband
//   LED-drive output, then idles out the rest of the 108 ms frame period.
//   Optional feature macro: IR_TX_REPEAT_EN. When defined, a held key
//   (tx_hold=1 at the end of a period) sends NEC repeat codes instead of
//   going idle; when undefined tx_hold is ignored.
//   Ports:
//     slow_clk : 16 kHz clock, the only clock
//     reset    : synchronous, active-high; aborts any frame silently
//     bus      : ir_nec_tx_if.slave (tx_data/tx_start/tx_hold in,
//                tx_busy/tx_done out)
//     ir_out   : 1 = mark (LED on), 0 = space
//   All duration parameters are in ticks and must not exceed 2047; the
//   longest possible frame must be shorter than FRAME_PERIOD.
// ---------------------------------------------------------------------------
module ir_nec_tx
  import ir_pkg::*;
#(
  parameter int unsigned LEAD_MARK    = IR_LEAD_MARK,
  parameter int unsigned LEAD_SPACE   = IR_LEAD_SPACE,
  parameter int unsigned BIT_MARK     = IR_BIT_MARK,
  parameter int unsigned ZERO_SPACE   = IR_ZERO_SPACE,
  parameter int unsigned ONE_SPACE    = IR_ONE_SPACE,
  parameter int unsigned REP_SPACE    = IR_REP_SPACE,
  parameter int unsigned FRAME_PERIOD = IR_FRAME_PERIOD
) (
  input  logic        slow_clk,
  input  logic        reset,
  ir_nec_tx_if.slave  bus,
  output logic        ir_out
);

  localparam int unsigned W = IR_TIMER_W;

  localparam logic [W-1:0] LEAD_MARK_T    = W'(LEAD_MARK);
  localparam logic [W-1:0] LEAD_SPACE_T   = W'(LEAD_SPACE);
  localparam logic [W-1:0] BIT_MARK_T     = W'(BIT_MARK);
  localparam logic [W-1:0] ZERO_SPACE_T   = W'(ZERO_SPACE);
  localparam logic [W-1:0] ONE_SPACE_T    = W'(ONE_SPACE);
  localparam logic [W-1:0] FRAME_PERIOD_T = W'(FRAME_PERIOD);
`ifdef IR_TX_REPEAT_EN
  localparam logic [W-1:0] REP_SPACE_T    = W'(REP_SPACE);
`endif

  // State and datapath registers
  ir_tx_state_t state_q, state_d;
  logic [31:0]  frame_q, frame_d;     // shift register, bit 31 is on air
  logic [4:0]   bit_cnt_q, bit_cnt_d; // data bits still to send, minus one
  logic [W-1:0] period_q, period_d;   // ticks since the current leader start

  // Segment timer handshake
  logic         tmr_load;
  logic [W-1:0] tmr_load_value;
  logic [W-1:0] tmr_value_unused;
  logic         tmr_expired;
  logic         done;

`ifndef IR_TX_REPEAT_EN
  // The hold input has no function without the repeat feature.
  logic hold_unused;
  assign hold_unused = bus.tx_hold;
  // REP_SPACE only matters to the repeat path.
  localparam int unsigned REP_SPACE_UNUSED = REP_SPACE;
`endif

  ir_tick_timer #(
    .WIDTH (W)
  ) u_timer (
    .slow_clk   (slow_clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .value      (tmr_value_unused),
    .expired    (tmr_expired)
  );

  // Next-state logic. Each transition into a timed segment reloads the timer
  // with that segment's length, so segments chain without dead cycles.
  always_comb begin
    state_d        = state_q;
    frame_d        = frame_q;
    bit_cnt_d      = bit_cnt_q;
    period_d       = period_q;
    tmr_load       = 1'b0;
    tmr_load_value = '0;
    done           = 1'b0;

    // The period counter free-runs while a frame or repeat is in progress;
    // the GAP exit below decides what it becomes next.
    if (state_q != ST_IDLE) begin
      period_d = period_q + {{(W-1){1'b0}}, 1'b1};
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.tx_start) begin
          state_d        = ST_LEAD_M;
          frame_d        = nec_encode(bus.tx_data);
          bit_cnt_d      = 5'd31;
          // Counts 1 on the first leader-mark cycle.
          period_d       = {{(W-1){1'b0}}, 1'b1};
          tmr_load       = 1'b1;
          tmr_load_value = LEAD_MARK_T;
        end
      end

      ST_LEAD_M: begin
        if (tmr_expired) begin
          state_d        = ST_LEAD_S;
          tmr_load       = 1'b1;
          tmr_load_value = LEAD_SPACE_T;
        end
      end

      ST_LEAD_S: begin
        if (tmr_expired) begin
          state_d        = ST_BIT_M;
          tmr_load       = 1'b1;
          tmr_load_value = BIT_MARK_T;
        end
      end

      ST_BIT_M: begin
        if (tmr_expired) begin
          state_d        = ST_BIT_S;
          tmr_load       = 1'b1;
          tmr_load_value = frame_q[31] ? ONE_SPACE_T : ZERO_SPACE_T;
        end
      end

      ST_BIT_S: begin
        if (tmr_expired) begin
          frame_d        = {frame_q[30:0], 1'b0};
          tmr_load       = 1'b1;
          tmr_load_value = BIT_MARK_T;
          if (bit_cnt_q == 5'd0) begin
            state_d = ST_STOP_M;
          end else begin
            state_d   = ST_BIT_M;
            bit_cnt_d = bit_cnt_q - 5'd1;
          end
        end
      end

      ST_STOP_M: begin
        if (tmr_expired) begin
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        if (period_q == FRAME_PERIOD_T) begin
`ifdef IR_TX_REPEAT_EN
          if (bus.tx_hold) begin
            // A repeat code starts a fresh period of its own.
            state_d        = ST_REP_M;
            period_d       = {{(W-1){1'b0}}, 1'b1};
            tmr_load       = 1'b1;
            tmr_load_value = LEAD_MARK_T;
          end else begin
            state_d  = ST_IDLE;
            period_d = '0;
            done     = 1'b1;
          end
`else
          state_d  = ST_IDLE;
          period_d = '0;
          done     = 1'b1;
`endif
        end
      end

`ifdef IR_TX_REPEAT_EN
      ST_REP_M: begin
        if (tmr_expired) begin
          state_d        = ST_REP_S;
          tmr_load       = 1'b1;
          tmr_load_value = REP_SPACE_T;
        end
      end

      ST_REP_S: begin
        if (tmr_expired) begin
          state_d        = ST_REP_STOP;
          tmr_load       = 1'b1;
          tmr_load_value = BIT_MARK_T;
        end
      end

      ST_REP_STOP: begin
        if (tmr_expired) begin
          state_d = ST_GAP;
        end
      end
`endif

      default: begin
        state_d  = ST_IDLE;
        period_d = '0;
      end
    endcase
  end

  always_ff @(posedge slow_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      period_q  <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      period_q  <= period_d;
    end
  end

  // Outputs decode straight from registered state, so a reset edge clears
  // ir_out and tx_busy immediately. tx_done depends on tx_hold in the final
  // GAP cycle because that is when the repeat decision is made.
  assign ir_out      = is_mark_state(state_q);
  assign bus.tx_busy = (state_q != ST_IDLE);
  assign bus.tx_done = done;

endmodule

// File: tb/tb_ir_nec_tx.sv
// ---------------------------------------------------------------------------
// tb_ir_nec_tx
//   Self-checking bench for ir_nec_tx. Captures ir_out cycle by cycle after
//   each accept, decodes the mark/space runs back into the 32-bit word and
//   checks timing of tx_done / tx_busy. Cycle k=1 is the first cycle after
//   the edge that accepted tx_start.
// ---------------------------------------------------------------------------
module tb_ir_nec_tx;

  localparam int WMAX = 8191;

  logic slow_clk = 1'b0;
  logic reset    = 1'b1;
  logic ir_out;

  ir_nec_tx_if bus();

  ir_nec_tx dut (
    .slow_clk (slow_clk),
    .reset    (reset),
    .bus      (bus),
    .ir_out   (ir_out)
  );

  always #5 slow_clk = ~slow_clk;

  logic wave [0:WMAX];
  int   n_vec = 0;
  int   n_bad = 0;
  int   done_cnt, done_at, busy_err;

  typedef struct {
    logic [15:0] data;
    logic [31:0] word;      // expected on-air word
    int          last_mark; // expected cycle of the final stop-mark tick
  } vec_t;

  vec_t vecs [5];

  initial begin
    #700000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge slow_clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  task automatic start_frame(input logic [15:0] d);
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    tick();
    bus.tx_start = 1'b0;
  endtask

  // Record ir_out for cycles 1..ncyc. busy is expected high up to busy_end
  // and low on the cycle after; later cycles are not busy-checked.
  task automatic capture(input int ncyc, input int busy_end, input bit repulse,
                         input bit keep_start, input int hold_until);
    for (int i = 0; i <= WMAX; i++) wave[i] = 1'b0;
    done_cnt = 0;
    done_at  = -1;
    busy_err = 0;
    for (int k = 1; k <= ncyc; k++) begin
      if (k > 1) tick();
      wave[k] = ir_out;
      if (bus.tx_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k <= busy_end + 1 && bus.tx_busy !== (k <= busy_end)) busy_err++;
      bus.tx_start = keep_start || (repulse && (k == 50 || k == 900));
      if (repulse && k == 50) bus.tx_data = 16'h0000;
      bus.tx_hold = (k < hold_until);
    end
  endtask

  function automatic int run_len(input int start, input logic lvl);
    int n = 0;
    while (start + n <= WMAX && wave[start + n] === lvl) n++;
    return n;
  endfunction

  function automatic int marks_in(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (wave[i] === 1'b1) n++;
    return n;
  endfunction

  // Parse leader + 32 bits + stop mark starting at cycle 1.
  task automatic decode(output logic [31:0] w, output int last_mark, output int bad);
    int pos, m, s;
    bad = 0;
    w   = '0;
    pos = 1;
    if (run_len(pos, 1'b1) != 144) bad++;
    pos += 144;
    if (run_len(pos, 1'b0) != 72) bad++;
    pos += 72;
    for (int b = 0; b < 32; b++) begin
      m = run_len(pos, 1'b1);
      if (m != 9) bad++;
      pos += 9;
      s = run_len(pos, 1'b0);
      if (s != 9 && s != 27) bad++;
      w = {w[30:0], (s == 27)};
      pos += (s == 27) ? 27 : 9;
    end
    if (run_len(pos, 1'b1) != 9) bad++;
    last_mark = pos + 8;
  endtask

  initial begin
    logic [31:0] w;
    int lm, bad, cnt, base;

    bus.tx_data  = 16'h0000;
    bus.tx_start = 1'b0;
    bus.tx_hold  = 1'b0;

    // Every frame has 16 ones and 16 zeros: 216 + 16*36 + 16*18 + 9 = 1089.
    vecs[0] = '{16'h0000, 32'hFF00FF00, 1089};
    vecs[1] = '{16'hA55A, 32'h5AA5A55A, 1089};
    vecs[2] = '{16'hFFFF, 32'h00FF00FF, 1089};
    vecs[3] = '{16'h1234, 32'hED12CB34, 1089};
    vecs[4] = '{16'hC03F, 32'h3FC0C03F, 1089};

    // Reset state, with a start request that must be ignored under reset.
    bus.tx_start = 1'b1;
    repeat (3) tick();
    check("reset_ir_out", ir_out, 0);
    check("reset_busy", bus.tx_busy, 0);
    check("reset_done", bus.tx_done, 0);
    bus.tx_start = 1'b0;
    reset = 1'b0;
    tick();
    check("idle_busy", bus.tx_busy, 0);

    // Table-driven single frames
    for (int v = 0; v < 5; v++) begin
      start_frame(vecs[v].data);
      capture(1729, 1728, 1'b0, 1'b0, 0);
      decode(w, lm, bad);
      $display("vec %0d data=%04h word=%08h last_mark=%0d done_at=%0d",
               v, vecs[v].data, w, lm, done_at);
      check("frame_word", w, vecs[v].word);
      check("frame_shape", bad, 0);
      check("frame_last_mark", lm, vecs[v].last_mark);
      check("gap_silent", marks_in(lm + 1, 1729), 0);
      check("done_count", done_cnt, 1);
      check("done_cycle", done_at, 1728);
      check("busy_window", busy_err, 0);
    end

    // tx_start re-pulsed mid-frame with different data: no effect
    start_frame(16'hA55A);
    capture(1729, 1728, 1'b1, 1'b0, 0);
    decode(w, lm, bad);
    $display("repulse word=%08h done_at=%0d", w, done_at);
    check("repulse_word", w, 32'h5AA5A55A);
    check("repulse_shape", bad, 0);
    check("repulse_marks", marks_in(1, 1729), 441);
    check("repulse_done", done_at, 1728);
    check("repulse_busy", busy_err, 0);

`ifndef IR_TX_REPEAT_EN
    // Without the repeat feature a held key still ends after one frame.
    bus.tx_hold = 1'b1;
    start_frame(16'h1234);
    capture(1729, 1728, 1'b0, 1'b0, 100000);
    decode(w, lm, bad);
    $display("hold_ignored word=%08h done_at=%0d", w, done_at);
    check("hold_word", w, 32'hED12CB34);
    check("hold_done", done_at, 1728);
    check("hold_busy", busy_err, 0);
    check("hold_gap_silent", marks_in(lm + 1, 1729), 0);
    bus.tx_hold = 1'b0;
`else
    // Held for three periods: frame plus three repeat codes.
    bus.tx_hold = 1'b1;
    start_frame(16'h1234);
    capture(6913, 6912, 1'b0, 1'b0, 5200);
    decode(w, lm, bad);
    $display("repeat word=%08h done_cnt=%0d done_at=%0d", w, done_cnt, done_at);
    check("rep_word", w, 32'hED12CB34);
    check("rep_frame_gap", marks_in(lm + 1, 1728), 0);
    for (int r = 1; r <= 3; r++) begin
      base = r * 1728 + 1;
      check("rep_mark", run_len(base, 1'b1), 144);
      check("rep_space", run_len(base + 144, 1'b0), 36);
      check("rep_stop", run_len(base + 180, 1'b1), 9);
      check("rep_gap", marks_in(base + 189, base + 1727), 0);
    end
    check("rep_done_count", done_cnt, 1);
    check("rep_done_cycle", done_at, 6912);
    check("rep_busy", busy_err, 0);
    bus.tx_hold = 1'b0;
`endif

    // Reset at cycle 400 aborts silently
    start_frame(16'h1234);
    repeat (399) tick();
    reset = 1'b1;
    tick();
    $display("reset_abort ir_out=%0b busy=%0b done=%0b", ir_out, bus.tx_busy, bus.tx_done);
    check("abort_ir_out", ir_out, 0);
    check("abort_busy", bus.tx_busy, 0);
    check("abort_done", bus.tx_done, 0);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 1800; k++) begin
      tick();
      if (bus.tx_done === 1'b1 || bus.tx_busy !== 1'b0 || ir_out !== 1'b0) cnt++;
    end
    check("abort_quiet", cnt, 0);
    start_frame(16'hC03F);
    capture(1729, 1728, 1'b0, 1'b0, 0);
    decode(w, lm, bad);
    $display("after_reset word=%08h done_at=%0d", w, done_at);
    check("post_reset_word", w, 32'h3FC0C03F);
    check("post_reset_shape", bad, 0);
    check("post_reset_done", done_at, 1728);

    // Back-to-back with tx_start held high
    bus.tx_data  = 16'h1234;
    bus.tx_start = 1'b1;
    tick();
    capture(2029, 1728, 1'b0, 1'b1, 0);
    $display("b2b done_at=%0d second_leader=%0d", done_at, run_len(1730, 1'b1));
    check("b2b_first_leader", run_len(1, 1'b1), 144);
    check("b2b_idle_cycle", wave[1729], 0);
    check("b2b_second_leader", run_len(1730, 1'b1), 144);
    check("b2b_done", done_at, 1728);
    check("b2b_busy", busy_err, 0);
    bus.tx_start = 1'b0;
    cnt = 0;
    while (bus.tx_busy === 1'b1 && cnt < 2000) begin
      tick();
      cnt++;
    end
    check("b2b_returns_idle", bus.tx_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
